// File: rtl/aes_mixcol_engine_pkg.sv
// rtl/aes_mixcol_engine_pkg.sv - shared constants and FSM state type for the MixColumns engine
package aes_mixcol_engine_pkg;

    localparam int         AES_STATE_W = 128;
    localparam int         AES_COLS    = 4;
    localparam logic [7:0] GF_POLY     = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mixcol_state_t;

endpackage

// File: rtl/gf256_mixcol_col.sv
// rtl/gf256_mixcol_col.sv - MixColumns / InvMixColumns on one 32-bit AES column
//
// Ports:
//   col  in  32  input column, row 0 in [31:24]
//   inv  in  1   1 = inverse matrix (only honoured when MIXCOL_INV_EN is defined)
//   res  out 32  transformed column, same row order
//
// Build option: MIXCOL_INV_EN adds the x4/x8 xtime chains and the inverse row sums;
// without it only the forward matrix exists and inv is ignored.
module gf256_mixcol_col (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);

    logic [7:0] b  [4];
    logic [7:0] x2 [4];
`ifdef MIXCOL_INV_EN
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign b[i] = col[31-8*i -: 8];
        gf256_xtime u_x2 (.a(b[i]), .y(x2[i]));
`ifdef MIXCOL_INV_EN
        gf256_xtime u_x4 (.a(x2[i]), .y(x4[i]));
        gf256_xtime u_x8 (.a(x4[i]), .y(x8[i]));
`endif
    end

    // Row r uses the base row rotated right by r: the coefficient for byte
    // (r+k)%4 is base[k].
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;
        logic [7:0] fwd;
        // 02*b[r] ^ 03*b[r+1] ^ b[r+2] ^ b[r+3]
        assign fwd = x2[r] ^ x2[R1] ^ b[R1] ^ b[R2] ^ b[R3];
`ifdef MIXCOL_INV_EN
        logic [7:0] rev;
        // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
        assign rev = (x8[r]  ^ x4[r]  ^ x2[r])
                   ^ (x8[R1] ^ x2[R1] ^ b[R1])
                   ^ (x8[R2] ^ x4[R2] ^ b[R2])
                   ^ (x8[R3] ^ b[R3]);
        assign res[31-8*r -: 8] = inv ? rev : fwd;
`else
        assign res[31-8*r -: 8] = fwd;
`endif
    end

endmodule

// File: rtl/gf256_xtime.sv
// rtl/gf256_xtime.sv - multiply a GF(2^8) element by x (0x02) modulo 0x11B
//
// Ports:
//   a  in  8  operand
//   y  out 8  a * 02 in GF(2^8)
module gf256_xtime
    import aes_mixcol_engine_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);

endmodule

// File: rtl/aes_mixcol_engine.sv
// rtl/aes_mixcol_engine.sv - iterative AES MixColumns/InvMixColumns engine with valid/ready handshake
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per BUSY cycle (1, 2 or 4)
//   TAG_W           sideband tag width
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      input item valid
//   in_ready   out  1      input accepted this cycle
//   in_state   in   128    AES state, byte 0 in [127:120]
//   in_inv     in   1      1 = InvMixColumns (only with MIXCOL_INV_EN)
//   in_tag     in   TAG_W  sideband tag
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_state  out  128    transformed state
//   out_tag    out  TAG_W  tag of the item in flight
//   busy       out  1      item in flight (BUSY or DONE)
//
// Build option: MIXCOL_INV_EN enables the inverse transform; otherwise in_inv is ignored.
module aes_mixcol_engine
    import aes_mixcol_engine_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int TAG_W          = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_inv,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    localparam int         NUM_PASSES = AES_COLS / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_PASS  = 2'(NUM_PASSES - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mixcol_state_t          state_q, state_d;
    logic [1:0]             col_cnt_q;
    logic [AES_STATE_W-1:0] data_q;
    logic [AES_STATE_W-1:0] nxt_data;
    logic [TAG_W-1:0]       tag_q;
    logic                   inv_q;
    logic                   ready_int;
    logic                   step;
    logic                   last_pass;
    logic                   load;

    logic [31:0] cols    [AES_COLS];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    for (genvar c = 0; c < AES_COLS; c++) begin : g_split
        assign cols[c] = data_q[AES_STATE_W-1-32*c -: 32];
    end

    // Engine g handles column col_cnt*COLS_PER_CYCLE + g of the current pass.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_eng
        logic [1:0] col_idx;
        assign col_idx   = 2'(col_cnt_q * COLS_PER_CYCLE + g);
        assign col_in[g] = cols[col_idx];
        gf256_mixcol_col u_col (
            .col (col_in[g]),
            .inv (inv_q),
            .res (col_out[g])
        );
    end

    // Column c is rewritten only in pass c/COLS_PER_CYCLE, by engine c%COLS_PER_CYCLE.
    for (genvar c = 0; c < AES_COLS; c++) begin : g_merge
        localparam int PASS = c / COLS_PER_CYCLE;
        localparam int SLOT = c % COLS_PER_CYCLE;
        assign nxt_data[AES_STATE_W-1-32*c -: 32] =
            (col_cnt_q == 2'(PASS)) ? col_out[SLOT] : cols[c];
    end

    assign last_pass = (col_cnt_q == LAST_PASS);

    always_comb begin
        state_d   = state_q;
        ready_int = 1'b0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (in_valid) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                step = 1'b1;
                if (last_pass) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    ready_int = 1'b1;
                    state_d   = in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // out_ready -> in_ready is combinational so a finished item can be
    // replaced in the same edge it is consumed.
    assign in_ready = ~rst & ready_int;
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_cnt_q <= 2'd0;
            data_q    <= '0;
            tag_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q    <= in_state;
                tag_q     <= in_tag;
                col_cnt_q <= 2'd0;
            end else if (step) begin
                data_q    <= nxt_data;
                col_cnt_q <= last_pass ? 2'd0 : col_cnt_q + 2'd1;
            end
        end
    end

`ifdef MIXCOL_INV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (load) begin
            inv_q <= in_inv;
        end
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign inv_q         = 1'b0;
`endif

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
    assign out_state = data_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// tb/tb_aes_mixcol_engine.sv - self-checking bench for aes_mixcol_engine
module tb_aes_mixcol_engine;

    localparam int TAG_W = 4;
    localparam int N_RAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0]     in_state, out_state;
    logic [TAG_W-1:0] in_tag, out_tag;

    logic             in_valid_4, in_ready_4, in_inv_4, out_valid_4, out_ready_4, busy_4;
    logic [127:0]     in_state_4, out_state_4;
    logic [TAG_W-1:0] in_tag_4, out_tag_4;

    int total = 0;
    int bad   = 0;

    aes_mixcol_engine #(.COLS_PER_CYCLE(1), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_tag(out_tag), .busy(busy)
    );

    aes_mixcol_engine #(.COLS_PER_CYCLE(4), .TAG_W(TAG_W)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_4), .in_ready(in_ready_4), .in_state(in_state_4),
        .in_inv(in_inv_4), .in_tag(in_tag_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4), .out_state(out_state_4),
        .out_tag(out_tag_4), .busy(busy_4)
    );

    // Carry-less product reduced by the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    // out[r] = sum_k M[r][k]*in[k] with M[r][k] = base[(k-r) mod 4].
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [31:0]  base;
        logic [31:0]  col;
        logic [7:0]   acc;
        logic [127:0] r;
        base = inv ? 32'h0e0b0d09 : 32'h02030101;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(base[31-8*((k - row + 4) % 4) -: 8], col[31-8*k -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic eff_inv(input logic i);
`ifdef MIXCOL_INV_EN
        return i;
`else
        return 1'b0 & i;
`endif
    endfunction

    task automatic send(input logic [127:0] s, input logic inv, input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        in_valid = 1'b1; in_state = s; in_inv = inv; in_tag = tag;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_accept: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic pop;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_state = '1; in_inv = 1'b1; in_tag = 4'hf; out_ready = 1'b1;
        in_valid_4 = 1'b0; in_state_4 = '0; in_inv_4 = 1'b0; in_tag_4 = '0; out_ready_4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        total++;
        if ({out_valid, busy} !== 2'b00 || out_state !== 128'h0 || out_tag !== 4'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b busy=%b state=%h tag=%h required 0 0 0 0",
                     out_valid, busy, out_state, out_tag);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forward;
        int n;
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 4'ha);
        wait_out(n);
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL fwd_latency: got %0d required 4", n);
        end
        total++;
        if (out_state !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 || out_tag !== 4'ha) begin
            bad++;
            $display("FAIL fwd_vector: state=%h tag=%h required 8e4da1bc9fdc589d01010101c6c6c6c6 a",
                     out_state, out_tag);
        end
        pop();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL fwd_drain: valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_cpc4;
        int n;
        in_valid_4 = 1'b1; in_inv_4 = 1'b0; in_tag_4 = 4'h9;
        in_state_4 = 128'hd4d4d4d5_2d26314c_db135345_01010101;
        #1;
        total++;
        if (in_ready_4 !== 1'b1) begin
            bad++; $display("FAIL cpc4_ready: got %b required 1", in_ready_4);
        end
        @(posedge clk); #1;
        in_valid_4 = 1'b0;
        n = 0;
        while (!out_valid_4 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL cpc4_latency: got %0d required 1", n);
        end
        total++;
        if (out_state_4 !== 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101 || out_tag_4 !== 4'h9) begin
            bad++;
            $display("FAIL cpc4_vector: state=%h tag=%h required d5d5d7d64d7ebdf88e4da1bc01010101 9",
                     out_state_4, out_tag_4);
        end
        out_ready_4 = 1'b1;
        @(posedge clk); #1;
        out_ready_4 = 1'b0;
    endtask

    task automatic test_inverse;
        int n;
        logic [127:0] exp_s;
`ifdef MIXCOL_INV_EN
        exp_s = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
`else
        exp_s = ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
`endif
        send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 4'h6);
        wait_out(n);
        total++;
        if (n !== 4 || out_state !== exp_s || out_tag !== 4'h6) begin
            bad++;
            $display("FAIL inverse_vector: n=%0d state=%h tag=%h required 4 %h 6", n, out_state, out_tag, exp_s);
        end
        pop();
    endtask

    task automatic test_back_to_back;
        int n;
        logic [127:0] sa, sb;
        logic stable, blocked;
        sa = {$urandom, $urandom, $urandom, $urandom};
        sb = {$urandom, $urandom, $urandom, $urandom};
        send(sa, 1'b0, 4'h5);
        wait_out(n);
        in_valid = 1'b1; in_state = sb; in_inv = 1'b1; in_tag = 4'h3;
        stable = 1'b1; blocked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (out_valid !== 1'b1 || out_state !== ref_mix(sa, 1'b0) || out_tag !== 4'h5) stable = 1'b0;
            if (in_ready !== 1'b0) blocked = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (!stable) begin
            bad++; $display("FAIL bp_stable: state=%h tag=%h required %h 5", out_state, out_tag, ref_mix(sa, 1'b0));
        end
        total++;
        if (!blocked) begin
            bad++; $display("FAIL bp_in_ready: in_ready went high while out_ready=0, required 0");
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_load: busy=%b valid=%b required 1 0", busy, out_valid);
        end
        wait_out(n);
        total++;
        if (out_state !== ref_mix(sb, eff_inv(1'b1)) || out_tag !== 4'h3) begin
            bad++;
            $display("FAIL b2b_result: state=%h tag=%h required %h 3", out_state, out_tag, ref_mix(sb, eff_inv(1'b1)));
        end
        pop();
    endtask

    task automatic test_reset_midop;
        bit stale;
        send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 4'h7);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midop_reset: valid=%b busy=%b in_ready=%b required 0 0 0", out_valid, busy, in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL midop_release_ready: got %b required 1", in_ready);
        end
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        out_ready = 1'b0;
        total++;
        if (stale) begin
            bad++; $display("FAIL midop_stale: out_valid=1 after reset, required 0");
        end
    endtask

    task automatic test_random;
        logic [127:0]     qs [$];
        logic [TAG_W-1:0] qt [$];
        int sent, got, cyc;
        bit acc;
        sent = 0; got = 0; cyc = 0;
        while (got < N_RAND && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid) begin
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_inv   = 1'($urandom);
                in_tag   = TAG_W'($urandom);
                if (sent < N_RAND && $urandom_range(0, 1) == 1) in_valid = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (qs.size() == 0) begin
                    bad++; $display("FAIL rand_unexpected: output tag=%h with nothing outstanding", out_tag);
                end else begin
                    if (out_state !== qs[0] || out_tag !== qt[0]) begin
                        bad++;
                        $display("FAIL rand_item%0d: state=%h tag=%h required %h %h",
                                 got, out_state, out_tag, qs[0], qt[0]);
                    end
                    void'(qs.pop_front());
                    void'(qt.pop_front());
                    got++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                qs.push_back(ref_mix(in_state, eff_inv(in_inv)));
                qt.push_back(in_tag);
                sent++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (got != N_RAND) begin
            bad++; $display("FAIL rand_timeout: received %0d required %0d", got, N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_cpc4();
        test_inverse();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
